// File: rtl/riscv_lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// funct3 width codes, FSM states and opcode constants.
package riscv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    function automatic logic f3_legal(
        input logic [2:0] f3,
        input logic       we
    );
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit (combinational).
// Store lanes/replication, load lane select/extension, misalign flag.
module lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [1:0]  eff_off,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_data,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sx;

    // Store side: lane enables, replicated data, natural alignment
    always_comb begin
        misalign = 1'b0;
        eff_off  = st_off;
        be       = 4'b1111;
        wdata    = st_data;
        unique case (1'b1)
            st_size == 2'b00: begin
                be    = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            st_size == 2'b01: begin
                misalign = st_off[0];
                eff_off  = {st_off[1], 1'b0};
                be       = st_off[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{st_data[15:0]}};
            end
            default: begin
                misalign = |st_off;
                eff_off  = 2'b00;
            end
        endcase
    end

    // Load side: pick the addressed lane and extend it
    always_comb begin
        byte_v = 8'(ld_data >> {ld_off, 3'b000});
        half_v = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
        sx     = ~ld_funct3[2];
        rdata  = ld_data;
        unique case (1'b1)
            ld_funct3[1:0] == 2'b00:
                rdata = {{24{sx & byte_v[7]}}, byte_v};
            ld_funct3[1:0] == 2'b01:
                rdata = {{16{sx & half_v[15]}}, half_v};
            default:
                rdata = ld_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: req/ack memory FSM with timeout and stall.
// LSU_MISALIGN_TRAP_EN: trap misaligned half/word instead of aligning.
module load_store_unit
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    lsu_state_t        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [3:0]        a_be;
    logic [31:0]       a_wdata;
    logic              a_misalign;
    logic [1:0]        a_eff_off;
    logic [31:0]       a_rdata;
    logic              bad;

    lsu_align u_align (
        .st_size   (req_funct3[1:0]),
        .st_off    (req_addr[1:0]),
        .st_data   (req_wdata),
        .be        (a_be),
        .wdata     (a_wdata),
        .misalign  (a_misalign),
        .eff_off   (a_eff_off),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .ld_data   (mem_rdata),
        .rdata     (a_rdata)
    );

    assign bad = !f3_legal(req_funct3, req_we) || (TRAP && a_misalign);

    // Next state, wait counter and registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d        = req_funct3;
                    off_d       = a_eff_off;
                    mem_we_d    = req_we;
                    mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    mem_be_d    = a_be;
                    mem_wdata_d = a_wdata;
                    rdata_d     = '0;
                    cnt_d       = '0;
                    if (bad) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = ACCESS;
                        mem_req_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    rdata_d   = a_rdata;
                    done_d    = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
                    mem_req_d = 1'b0;
                    rdata_d   = '0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign stall     = req_valid && (state_q != RESP);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// Directed cases plus random stream against a byte-level model.
module tb_load_store_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp;
    int n_bad;

    typedef struct packed {
        bit          finished;
        int          n;
        int          stall_cnt;
        int          req_cycles;
        logic        stall_done;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        we;
        logic        err;
        logic        done_after;
        bit          unstable;
    } obs_t;

    typedef struct packed {
        bit          bad;
        int          n;
        int          req_cycles;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        err;
    } exp_t;

    load_store_unit #(
        .ADDR_W   (32),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wd,
        input int          ack_at,
        input logic [31:0] mrd
    );
        exp_t        e;
        int          size;
        int          off;
        int          aoff;
        bit          legal;
        logic [31:0] v;
        e     = '0;
        size  = 1 << f3[1:0];
        off   = int'(addr[1:0]);
        legal = we ? (f3 <= 3'd2)
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        aoff  = off - (off % size);
        e.bad = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((off % size) != 0) e.bad = 1'b1;
`endif
        e.addr = addr & 32'hFFFF_FFFC;
        e.be   = 4'(((1 << size) - 1) << aoff);
        if (size == 1)
            e.wdata = {24'b0, wd[7:0]} * 32'h0101_0101;
        else if (size == 2)
            e.wdata = {16'b0, wd[15:0]} * 32'h0001_0001;
        else
            e.wdata = wd;
        v = mrd >> (8 * aoff);
        if (size == 1)
            e.rdata = (!f3[2] && v[7]) ? (v | 32'hFFFF_FF00)
                                       : (v & 32'h0000_00FF);
        else if (size == 2)
            e.rdata = (!f3[2] && v[15]) ? (v | 32'hFFFF_0000)
                                        : (v & 32'h0000_FFFF);
        else
            e.rdata = mrd;
        if (e.bad) begin
            e.n = 1; e.err = 1'b1; e.rdata = '0; e.req_cycles = 0;
        end else if (ack_at < 1 || ack_at > MAX_WAIT) begin
            e.n = MAX_WAIT + 1; e.err = 1'b1; e.rdata = '0;
            e.req_cycles = MAX_WAIT;
        end else begin
            e.n = ack_at + 1; e.req_cycles = ack_at;
        end
        return e;
    endfunction

    // Drives one request (starting just after a negedge) and records what
    // the DUT did until the done pulse, plus the cycle after it.
    task automatic run_txn(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  int          ack_at,
        input  logic [31:0] mrd,
        input  bit          drop,
        input  bit          junk,
        output obs_t        o
    );
        o = '0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (done) begin
                o.finished   = 1'b1;
                o.n          = i;
                o.err        = err;
                o.rdata      = rdata;
                o.stall_done = stall;
                req_valid    = 1'b0;
                mem_ack      = 1'b0;
                @(negedge clk);
                #1;
                o.done_after = done;
                return;
            end
            if (stall) o.stall_cnt++;
            if (mem_req) begin
                if (o.req_cycles == 0) begin
                    o.addr  = mem_addr;
                    o.be    = mem_be;
                    o.wdata = mem_wdata;
                    o.we    = mem_we;
                end else if ({mem_addr, mem_be, mem_wdata, mem_we}
                             != {o.addr, o.be, o.wdata, o.we}) begin
                    o.unstable = 1'b1;
                end
                o.req_cycles++;
                mem_ack   = (o.req_cycles == ack_at);
                mem_rdata = mem_ack ? mrd : $urandom();
                if (drop) req_valid = 1'b0;
            end else begin
                mem_ack   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = $urandom();
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = 1'b1;
        #12;
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata,
             rdata, done, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outs got req=%b addr=%h be=%b rdata=%h done=%b err=%b want all 0",
                     mem_req, mem_addr, mem_be, rdata, done, err);
        end
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_stall got %b want 1", stall);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic        we[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3[5]  = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd0};
        logic [31:0] ad[5]  = '{32'h40, 32'h43, 32'h43, 32'h42, 32'h41};
        logic [31:0] wd[5]  = '{32'hDEAD_BEEF, 32'h0, 32'h0,
                                32'h0000_ABCD, 32'h0000_0055};
        int          ak[5]  = '{2, 1, 1, 1, 1};
        logic [31:0] mr[5]  = '{32'h0, 32'h80FF_1234, 32'h80FF_1234,
                                32'h0, 32'h0};
        logic [3:0]  xbe[5] = '{4'b1111, 4'b1000, 4'b1000,
                                4'b1100, 4'b0010};
        logic [31:0] xwd[5] = '{32'hDEAD_BEEF, 32'h0, 32'h0,
                                32'hABCD_ABCD, 32'h5555_5555};
        logic [31:0] xrd[5] = '{32'h0, 32'hFFFF_FF80, 32'h0000_0080,
                                32'h0, 32'h0};
        int          xst[5] = '{3, 2, 2, 2, 2};
        obs_t o;
        for (int k = 0; k < 5; k++) begin
            run_txn(we[k], f3[k], ad[k], wd[k], ak[k], mr[k], 0, 0, o);
            n_cmp++;
            if (!o.finished || o.n != xst[k] || o.stall_cnt != xst[k]) begin
                n_bad++;
                $display("FAIL dir%0d timing got fin=%0d n=%0d stall=%0d want n=stall=%0d",
                         k, o.finished, o.n, o.stall_cnt, xst[k]);
            end
            n_cmp++;
            if (o.stall_done !== 1'b0 || o.done_after !== 1'b0
                || o.err !== 1'b0) begin
                n_bad++;
                $display("FAIL dir%0d resp got stall=%b done_next=%b err=%b want 0 0 0",
                         k, o.stall_done, o.done_after, o.err);
            end
            n_cmp++;
            if (o.addr !== (ad[k] & 32'hFFFF_FFFC) || o.be !== xbe[k]
                || o.we !== we[k]) begin
                n_bad++;
                $display("FAIL dir%0d mem got addr=%h be=%b we=%b want %h %b %b",
                         k, o.addr, o.be, o.we, ad[k] & 32'hFFFF_FFFC,
                         xbe[k], we[k]);
            end
            n_cmp++;
            if (we[k] ? (o.wdata !== xwd[k]) : (o.rdata !== xrd[k])) begin
                n_bad++;
                $display("FAIL dir%0d data got wdata=%h rdata=%h want %h",
                         k, o.wdata, o.rdata, we[k] ? xwd[k] : xrd[k]);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(1'b0, 3'd2, 32'h80, 32'h0, 0, 32'h0, 0, 0, o);
        n_cmp++;
        if (!o.finished || o.req_cycles != MAX_WAIT || o.n != MAX_WAIT + 1) begin
            n_bad++;
            $display("FAIL timeout_len got fin=%0d req_cycles=%0d n=%0d want %0d %0d",
                     o.finished, o.req_cycles, o.n, MAX_WAIT, MAX_WAIT + 1);
        end
        n_cmp++;
        if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.done_after !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_resp got err=%b rdata=%h done_next=%b want 1 0 0",
                     o.err, o.rdata, o.done_after);
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  f3[4] = '{3'd2, 3'd1, 3'd5, 3'd2};
        logic        we[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad[4] = '{32'h41, 32'h103, 32'h207, 32'h302};
        obs_t o;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e = model(we[k], f3[k], ad[k], 32'h1234_5678, 1, 32'hC3A5_9F81);
            run_txn(we[k], f3[k], ad[k], 32'h1234_5678, 1, 32'hC3A5_9F81,
                    0, 0, o);
            n_cmp++;
            if (!o.finished || o.err !== e.err || o.req_cycles != e.req_cycles
                || o.n != e.n) begin
                n_bad++;
                $display("FAIL mis%0d got err=%b req_cycles=%0d n=%0d want %b %0d %0d",
                         k, o.err, o.req_cycles, o.n, e.err, e.req_cycles, e.n);
            end
            n_cmp++;
            if (!e.bad && (o.be !== e.be || o.addr !== e.addr
                || (!we[k] && o.rdata !== e.rdata)
                || (we[k] && o.wdata !== e.wdata))) begin
                n_bad++;
                $display("FAIL mis%0d lanes got addr=%h be=%b rdata=%h wdata=%h want %h %b %h %h",
                         k, o.addr, o.be, o.rdata, o.wdata,
                         e.addr, e.be, e.rdata, e.wdata);
            end
            if (k == 0) begin
                n_cmp++;
`ifdef LSU_MISALIGN_TRAP_EN
                if (o.err !== 1'b1 || o.req_cycles != 0) begin
                    n_bad++;
                    $display("FAIL lw_0x41 got err=%b req_cycles=%0d want 1 0",
                             o.err, o.req_cycles);
                end
`else
                if (o.err !== 1'b0 || o.addr !== 32'h40 || o.be !== 4'b1111) begin
                    n_bad++;
                    $display("FAIL lw_0x41 got err=%b addr=%h be=%b want 0 40 1111",
                             o.err, o.addr, o.be);
                end
`endif
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t        o;
        exp_t        e;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] ad, wd, mr;
        int          ak, xst;
        bit          drop, junk;
        for (int k = 0; k < 150; k++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            ad   = $urandom();
            wd   = $urandom();
            mr   = $urandom();
            ak   = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
            drop = ($urandom_range(0, 3) == 0);
            junk = 1'($urandom_range(0, 1));
            e    = model(we, f3, ad, wd, ak, mr);
            run_txn(we, f3, ad, wd, ak, mr, drop, junk, o);
            xst  = (drop && e.n > 2) ? 2 : e.n;
            n_cmp++;
            if (!o.finished || o.n != e.n || o.stall_cnt != xst
                || o.req_cycles != e.req_cycles) begin
                n_bad++;
                $display("FAIL rnd%0d timing got fin=%0d n=%0d stall=%0d req=%0d want %0d %0d %0d",
                         k, o.finished, o.n, o.stall_cnt, o.req_cycles,
                         e.n, xst, e.req_cycles);
            end
            n_cmp++;
            if (o.err !== e.err || o.done_after !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd%0d err got %b done_next=%b want %b 0",
                         k, o.err, o.done_after, e.err);
            end
            if (e.req_cycles > 0) begin
                n_cmp++;
                if (o.addr !== e.addr || o.be !== e.be || o.we !== we
                    || o.unstable || (we && o.wdata !== e.wdata)) begin
                    n_bad++;
                    $display("FAIL rnd%0d mem got addr=%h be=%b we=%b wd=%h unst=%0d want %h %b %b %h",
                             k, o.addr, o.be, o.we, o.wdata, o.unstable,
                             e.addr, e.be, we, e.wdata);
                end
            end
            if (!we || e.err) begin
                n_cmp++;
                if (o.rdata !== e.rdata) begin
                    n_bad++;
                    $display("FAIL rnd%0d rdata got %h want %h f3=%0d addr=%h",
                             k, o.rdata, e.rdata, f3, ad);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        bit   seen;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h100;
        mem_ack    = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre got mem_req=%b want 1", mem_req);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_async got req=%b addr=%h done=%b want 0 0 0",
                     mem_req, mem_addr, done);
        end
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        seen      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (done || mem_req || stall) seen = 1'b1;
        end
        mem_ack = 1'b0;
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL rstmid_idle got activity=1 want 0");
        end
        e = model(1'b0, 3'd1, 32'h202, 32'h0, 2, 32'h8001_7FFF);
        run_txn(1'b0, 3'd1, 32'h202, 32'h0, 2, 32'h8001_7FFF, 0, 0, o);
        n_cmp++;
        if (!o.finished || o.rdata !== e.rdata || o.err !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_after got fin=%0d rdata=%h err=%b want %h 0",
                     o.finished, o.rdata, o.err, e.rdata);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        test_reset();
        test_directed();
        test_timeout();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
